// File: rtl/out_uart_tx.sv
// OUT-port trace: queues every nibble the core writes, converts it to one ASCII
// hex character and sends it as an 8N1 UART frame on tx.
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          out_we,
    input  logic [3:0]                    out_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [1:0]                    state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   PTR_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Handshake: out_we is a valid with no ready; the core never stalls, so a
    // write that meets a full FIFO with no pop on that edge is dropped and
    // recorded in overflow.
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [AW:0]   level_w;
    logic          empty_w, full_w, baud_done, pop, push;
    logic [3:0]    head;
    logic [7:0]    head_ascii;

    always_comb begin
        level_w    = wr_ptr_q - rd_ptr_q;
        empty_w    = (level_w == '0);
        full_w     = (level_w == PTR_FULL);
        head       = mem_q[rd_ptr_q[AW-1:0]];
        head_ascii = (head < 4'd10) ? {4'h3, head} : 8'h37 + {4'h0, head};
        baud_done  = (cnt_q == CNT_LAST);

        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!empty_w) begin
                    pop     = 1'b1;
                    shift_d = head_ascii;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            default: begin
                // Stop bit: chain straight into the next start bit when data waits.
                if (baud_done) begin
                    cnt_d = '0;
                    if (!empty_w) begin
                        pop     = 1'b1;
                        shift_d = head_ascii;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase

        push     = out_we && (!full_w || pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | (out_we && full_w && !pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= out_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign fifo_empty = empty_w;
    assign fifo_full  = full_w;
    assign level      = level_w;
    assign overflow   = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: frame-level model compared every cycle, a line receiver
// that decodes tx, and directed scenarios with literal expected characters.
module tb_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FL    = 10 * CPB;

  logic       clk;
  logic       reset;
  logic       out_we;
  logic [3:0] out_data;
  logic       tx, busy, fifo_empty, fifo_full, overflow;
  logic [3:0] level;
  logic [1:0] state_dbg;

  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .out_we(out_we), .out_data(out_data),
    .tx(tx), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .level(level), .overflow(overflow), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a 10*CPB cycle window; pos is the cycle within it (-1 = line idle).
  int          m_q[$];
  int          m_pos = -1;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_ch = 8'h00;

  function automatic logic [7:0] to_ascii(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
  endfunction

  function automatic logic model_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_ch[k-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pos = -1;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic was_full, do_pop;
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() > 0) && (m_pos < 0 || m_pos == FL - 1);
    if (do_pop) begin
      m_ch  = to_ascii(m_q.pop_front());
      m_pos = 0;
    end else if (m_pos == FL - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (out_we) begin
      if (!was_full || do_pop) m_q.push_back(int'(out_data));
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process + line receiver ----------------
  int         ncyc = 0;
  int         busy_cnt = 0;
  int         peak_level = 0;
  int         rx_cnt = -1;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      check("cyc_tx", {31'd0, tx}, {31'd0, model_tx()});
      check("cyc_busy", {31'd0, busy}, {31'd0, m_pos >= 0});
      check("cyc_empty", {31'd0, fifo_empty}, {31'd0, m_q.size() == 0});
      check("cyc_full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
      check("cyc_level", {28'd0, level}, m_q.size());
      check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (busy) busy_cnt++;
      if (int'(level) > peak_level) peak_level = int'(level);
      if (reset) begin
        rx_cnt = -1;
      end else if (rx_cnt < 0) begin
        if (tx == 1'b0) begin
          rx_cnt = 0;
          rx_start_q.push_back(ncyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == 0) begin
          if (rx_cnt / CPB <= 8) begin
            rx_byte[rx_cnt / CPB - 1] = tx;
          end else begin
            check("rx_stop_bit", {31'd0, tx}, 32'd1);
            rx_q.push_back(rx_byte);
            rx_cnt = -1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [3:0] d);
    @(posedge clk);
    #1;
    out_we   = we;
    out_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0);
  endtask

  // ---------------- scoreboard on received characters ----------------
  logic [7:0] exp_q[$];

  task automatic check_rx(input string name, input string s);
    logic [7:0] e;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) check({name, "_char"}, {24'd0, rx_q.pop_front()}, {24'd0, e});
      else check({name, "_missing"}, 32'd0, {24'd0, e});
    end
    rx_q.delete();
    rx_start_q.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset    = 1'b1;
    out_we   = 1'b0;
    out_data = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);

    // single 0x3 -> '3' (0x33), busy exactly one frame, latency one edge
    busy_cnt = 0;
    drive(1'b1, 4'h3);
    drive(1'b0, 4'h0);
    check("lat_tx_before_pop", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    check("lat_tx_start", {31'd0, tx}, 32'd0);
    check("lat_busy", {31'd0, busy}, 32'd1);
    idle(45);
    check("one_busy_cycles", busy_cnt, 32'd40);
    check("one_level", {28'd0, level}, 32'd0);
    check_rx("one", "3");

    // back-to-back 0xA, 0xF -> 'A','F' with 40-cycle start spacing
    drive(1'b1, 4'hA);
    drive(1'b1, 4'hF);
    idle(90);
    if (rx_start_q.size() == 2) check("b2b_spacing", rx_start_q[1] - rx_start_q[0], 32'd40);
    else check("b2b_starts", rx_start_q.size(), 32'd2);
    check_rx("b2b", "AF");

    // 10-write burst from idle: 9 accepted, one dropped
    peak_level = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i));
    drive(1'b0, 4'h0);
    check("burst_full", {31'd0, fifo_full}, 32'd1);
    check("burst_overflow", {31'd0, overflow}, 32'd1);
    idle(380);
    check("burst_peak", peak_level, 32'd8);
    check("burst_overflow_sticky", {31'd0, overflow}, 32'd1);
    check_rx("burst", "012345678");

    // reset during data bit 3 of '5' (bit 3 of 0x35 is 0)
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h6);
    drive(1'b1, 4'h7);
    drive(1'b0, 4'h0);
    repeat (15) @(posedge clk);
    #1;
    check("rst_mid_tx_before", {31'd0, tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_level", {28'd0, level}, 32'd0);
    check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rx_q.delete();
    rx_start_q.delete();
    idle(60);
    check("rst_mid_no_frame", rx_q.size(), 32'd0);
    check("rst_mid_tx_idle", {31'd0, tx}, 32'd1);

    // full FIFO with a write landing on the stop-bit popping edge
    for (int i = 0; i < 9; i++) drive(1'b1, 4'(i));
    idle(32);
    check("full_pop_pre_level", {28'd0, level}, 32'd8);
    drive(1'b1, 4'hC);
    drive(1'b0, 4'h0);
    check("full_pop_level", {28'd0, level}, 32'd8);
    check("full_pop_full", {31'd0, fifo_full}, 32'd1);
    check("full_pop_overflow", {31'd0, overflow}, 32'd0);
    idle(420);
    check_rx("full_pop", "012345678C");

    // all sixteen nibbles, one per frame
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      drive(1'b0, 4'h0);
      idle(44);
    end
    check_rx("hex", "0123456789ABCDEF");
    check("end_empty", {31'd0, fifo_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Serial output stage for the 4-bit processor: consumes every value the OUT instruction writes to the output port, queues it in a small FIFO, converts each nibble to one ASCII hex character, and transmits it as an 8N1 UART frame. It sits directly downstream of the processor's output-register write strobe and data bus, giving the design a host-visible trace of all OUT activity without stalling the core.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 8: queue entries; power of two, ≥ 2.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears FIFO, FSM, flags.
- out_we  input  1  OUT write strobe; the processor's output-register enable, sampled on the same edge.
- out_data  input  4  nibble on the data bus during out_we.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is in START/DATA/STOP.
- fifo_empty  output  1  no queued entries.
- fifo_full  output  1  FIFO_DEPTH entries queued.
- level  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
- overflow  output  1  sticky: a write was dropped; cleared only by reset.

## Operation
- Write: at a rising edge with out_we=1, out_data is pushed unless FIFO is full with no pop on that edge.
- Drop: a push while full and no simultaneous pop discards the nibble and sets overflow; FIFO contents unchanged.
- Simultaneous push and pop at full: both happen; level stays FIFO_DEPTH; no overflow.
- No bypass: an entry pushed on edge N can be popped at the earliest on edge N+1.
- Conversion at pop: 0x0–0x9 → 0x30–0x39; 0xA–0xF → 0x41–0x46 (uppercase).
- Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop, load shift register, go START.
  - START → DATA after CLKS_PER_BIT cycles; bit index 0.
  - DATA: after CLKS_PER_BIT cycles shift; after bit 7 go STOP.
  - STOP: after CLKS_PER_BIT cycles, if FIFO non-empty pop and go START directly; else go IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, restarts at every state entry; no drift between frames.
- FIFO pointers wrap modulo FIFO_DEPTH; level is pointer difference, not wrapped.
- tx is a register output (glitch-free).

## Timing
- Reset values: tx=1, busy=0, fifo_empty=1, fifo_full=0, level=0, overflow=0, FSM=IDLE.
- Reset mid-frame: tx returns high asynchronously; queued data lost; transmission does not resume after release.
- Latency: write on edge N into empty FIFO with FSM IDLE → pop on edge N+1, tx=0 and busy=1 from N+1.
- Frame length: 10×CLKS_PER_BIT cycles from tx falling to end of stop bit.
- Back-to-back: with FIFO non-empty, next start bit begins immediately after stop bit; period exactly 10×CLKS_PER_BIT.
- busy falls on the edge STOP→IDLE; fifo_empty/fifo_full/level update on the push/pop edge.
- Capacity in a burst from idle: FIFO_DEPTH+1 consecutive writes accepted (first one popped on second edge).

## Test plan
- CLKS_PER_BIT=4, write 0x3 → tx low 4 cycles, then bits 1,1,0,0,1,1,0,0 (0x33 LSB first) 4 cycles each, high stop 4 cycles; busy high 40 cycles, level back to 0.
- Write 0xA then 0xF back-to-back → frames 0x41 then 0x46, second start bit begins exactly 40 cycles after first (CLKS_PER_BIT=4).
- FIFO_DEPTH=8, 10 writes on consecutive edges while idle → first 9 accepted, level peaks 8, fifo_full=1, overflow=1, exactly 9 frames with correct characters in order.
- FIFO full and stop bit ending: assert out_we on the popping edge → level stays 8, overflow stays 0, written value transmitted last.
- Assert reset during DATA bit 3 → tx=1 immediately, busy=0, level=0, overflow=0; after release no frame emitted until new write.
- Write all 16 values 0x0–0xF paced one per frame → received characters "0123456789ABCDEF".
